// File: rtl/serial_config_rx.sv
// 3-wire configuration receiver: synchronises an asynchronous serial port, decodes
// 32-bit frames (12-bit header, 4-bit address, 16-bit data) and commits them to a 16x16 register file.
module serial_config_rx #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] REG_RESET   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adc3wire_clk,
  input  logic        adc3wire_data,
  input  logic        adc3wire_strobe,
  input  logic [3:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        wr_pulse,
  output logic [3:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err,
  output logic        busy
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_SHIFT  = 2'd1;
  localparam logic [1:0]  S_COMMIT = 2'd2;
  localparam logic [11:0] HDR_OK   = 12'h001;
  localparam logic [5:0]  CNT_FULL = 6'd32;
  localparam logic [5:0]  CNT_SAT  = 6'd33;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic [SYNC_STAGES-1:0] stb_sync_q;
  logic [SYNC_STAGES-1:0] sync_vld_q;

  logic        sclk_s, data_s, stb_s;
  logic        sclk_prev_q, stb_prev_q;
  logic        arm_q, arm_d;
  logic        pend_q, pend_d;
  logic [1:0]  state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        wr_pulse_q, wr_pulse_d;
  logic        frame_err_q, frame_err_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [15:0] rd_data_q;
  logic [15:0] regfile_q [16];
  logic        we;
  logic        sclk_rise, stb_rise, stb_fall, frame_ok;

  // Synchroniser chains; strobe idles high. sync_vld_q marks when the chains hold real samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      data_sync_q <= '0;
      stb_sync_q  <= '1;
      sync_vld_q  <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], adc3wire_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], adc3wire_data};
      stb_sync_q  <= {stb_sync_q[SYNC_STAGES-2:0], adc3wire_strobe};
      sync_vld_q  <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign stb_s  = stb_sync_q[SYNC_STAGES-1];

  // A strobe already low at reset release must not start a frame: arm only after a real high.
  assign arm_d     = arm_q | (sync_vld_q[SYNC_STAGES-1] & stb_s);
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign stb_rise  = stb_s & ~stb_prev_q;
  assign stb_fall  = arm_q & stb_prev_q & ~stb_s;
  assign frame_ok  = (cnt_q == CNT_FULL) && (shift_q[31:20] == HDR_OK);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    wr_pulse_d  = 1'b0;
    frame_err_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    we          = 1'b0;
    case (state_q)
      S_IDLE: begin
        pend_d = 1'b0;
        if (stb_fall || (pend_q && !stb_s)) begin
          state_d = S_SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        // Strobe rise wins over a coincident clock edge; that edge is not sampled.
        if (stb_rise) begin
          state_d = S_COMMIT;
          if (frame_ok) begin
            we         = 1'b1;
            wr_pulse_d = 1'b1;
            wr_addr_d  = shift_q[19:16];
            wr_data_d  = shift_q[15:0];
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          shift_d = {shift_q[30:0], data_s};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 6'd1;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (stb_fall) pend_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      sclk_prev_q <= 1'b0;
      stb_prev_q  <= 1'b1;
      arm_q       <= 1'b0;
      pend_q      <= 1'b0;
      wr_pulse_q  <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      sclk_prev_q <= sclk_s;
      stb_prev_q  <= stb_s;
      arm_q       <= arm_d;
      pend_q      <= pend_d;
      wr_pulse_q  <= wr_pulse_d;
      frame_err_q <= frame_err_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Read samples the pre-write contents, so a same-cycle write shows up one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regfile_q[i] <= REG_RESET;
      rd_data_q <= REG_RESET;
    end else begin
      if (we) regfile_q[wr_addr_d] <= wr_data_d;
      rd_data_q <= regfile_q[rd_addr];
    end
  end

  assign rd_data   = rd_data_q;
  assign wr_pulse  = wr_pulse_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == S_SHIFT);

endmodule

// File: tb/tb_serial_config_rx.sv
// Directed bench for serial_config_rx: table of single frames plus hand-written
// back-to-back, read-during-write and mid-frame reset sequences.
module tb_serial_config_rx;

  localparam logic [15:0] RST_VAL = 16'hC0DE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk, sdat, stb;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        wr_pulse;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_err;
  logic        busy;

  serial_config_rx #(.SYNC_STAGES(2), .REG_RESET(RST_VAL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .adc3wire_clk   (sclk),
    .adc3wire_data  (sdat),
    .adc3wire_strobe(stb),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .wr_pulse       (wr_pulse),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .frame_err      (frame_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          nbits;
    bit          ok;
    logic [3:0]  exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] mdl [16];
  logic [3:0]  exp_wa;
  logic [15:0] exp_wd;
  int checks = 0;
  int errors = 0;
  int n_wr = 0, n_err = 0, n_both = 0;
  int p0, e0;
  bit seen;

  always @(negedge clk) begin
    if (wr_pulse) n_wr++;
    if (frame_err) n_err++;
    if (wr_pulse && frame_err) n_both++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clock_bits(input logic [31:0] word, input int n);
    for (int i = 0; i < n; i++) begin
      sdat = (i < 32) ? word[31-i] : 1'b0;
      repeat (8) @(negedge clk);
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] word, input int n, input int gap);
    @(negedge clk) stb = 1'b0;
    repeat (8) @(negedge clk);
    clock_bits(word, n);
    repeat (8) @(negedge clk);
    stb = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic read_check(input logic [3:0] a);
    @(negedge clk) rd_addr = a;
    @(posedge clk);
    #1 chk($sformatf("rd_data[%0d]", a), {16'h0, rd_data}, {16'h0, mdl[a]});
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) read_check(a[3:0]);
  endtask

  initial begin
    vecs[0] = '{32'h0015BEEF, 32, 1'b1, 4'h5, 16'hBEEF};
    vecs[1] = '{32'h0015BEEF, 31, 1'b0, 4'h0, 16'h0000};
    vecs[2] = '{32'h0015BEEF, 33, 1'b0, 4'h0, 16'h0000};
    vecs[3] = '{32'h0025BEEF, 32, 1'b0, 4'h0, 16'h0000};
    vecs[4] = '{32'h001A1234, 32, 1'b1, 4'hA, 16'h1234};
    vecs[5] = '{32'h00137777, 32, 1'b1, 4'h3, 16'h7777};
    for (int a = 0; a < 16; a++) mdl[a] = RST_VAL;
    exp_wa = '0;
    exp_wd = '0;

    rst_n = 1'b0; sclk = 1'b0; sdat = 1'b0; stb = 1'b1; rd_addr = 4'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_wr_pulse", {31'h0, wr_pulse}, 32'h0);
    chk("reset_frame_err", {31'h0, frame_err}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_wr_addr", {28'h0, wr_addr}, 32'h0);
    chk("reset_wr_data", {16'h0, wr_data}, 32'h0);
    chk("reset_rd_data", {16'h0, rd_data}, {16'h0, RST_VAL});

    for (int v = 0; v < 6; v++) begin
      p0 = n_wr;
      e0 = n_err;
      send_frame(vecs[v].word, vecs[v].nbits, 12);
      if (vecs[v].ok) begin
        mdl[vecs[v].exp_addr] = vecs[v].exp_data;
        exp_wa = vecs[v].exp_addr;
        exp_wd = vecs[v].exp_data;
      end
      chk($sformatf("vec%0d_wr_pulse_cycles", v), n_wr - p0, vecs[v].ok ? 1 : 0);
      chk($sformatf("vec%0d_frame_err_cycles", v), n_err - e0, vecs[v].ok ? 0 : 1);
      chk($sformatf("vec%0d_wr_addr", v), {28'h0, wr_addr}, {28'h0, exp_wa});
      chk($sformatf("vec%0d_wr_data", v), {16'h0, wr_data}, {16'h0, exp_wd});
      read_all();
    end

    // Back-to-back frames with a 4-cycle strobe gap, then with a 1-cycle gap
    p0 = n_wr; e0 = n_err;
    send_frame(32'h00101234, 32, 4);
    send_frame(32'h001FA5A5, 32, 12);
    mdl[0] = 16'h1234; mdl[15] = 16'hA5A5;
    chk("b2b_wr_pulse_cycles", n_wr - p0, 2);
    chk("b2b_frame_err_cycles", n_err - e0, 0);
    chk("b2b_wr_addr", {28'h0, wr_addr}, 32'hF);
    chk("b2b_wr_data", {16'h0, wr_data}, 32'hA5A5);
    read_check(4'h0);
    read_check(4'hF);

    p0 = n_wr; e0 = n_err;
    send_frame(32'h00126666, 32, 1);
    send_frame(32'h00135555, 32, 12);
    mdl[2] = 16'h6666; mdl[3] = 16'h5555;
    chk("gap1_wr_pulse_cycles", n_wr - p0, 2);
    chk("gap1_frame_err_cycles", n_err - e0, 0);
    read_check(4'h2);
    read_check(4'h3);

    // Read-during-write on address 3
    @(negedge clk) rd_addr = 4'h3;
    send_frame(32'h00134242, 32, 0);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (wr_pulse) begin
        chk("rdw_old_value", {16'h0, rd_data}, 32'h5555);
        @(posedge clk);
        #1 chk("rdw_new_value", {16'h0, rd_data}, 32'h4242);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("rdw_wr_pulse_timeout", 32'h0, 32'h1);
    mdl[3] = 16'h4242;
    exp_wa = 4'h3; exp_wd = 16'h4242;
    repeat (12) @(negedge clk);

    // Reset mid-frame with strobe held low through release
    p0 = n_wr; e0 = n_err;
    @(negedge clk) stb = 1'b0;
    repeat (8) @(negedge clk);
    clock_bits(32'h0017ABCD, 16);
    chk("midframe_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_low_strobe_busy", {31'h0, busy}, 32'h0);
    stb = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_abort_wr_pulse", n_wr - p0, 0);
    chk("rst_abort_frame_err", n_err - e0, 0);
    chk("rst_wr_addr", {28'h0, wr_addr}, 32'h0);
    chk("rst_wr_data", {16'h0, wr_data}, 32'h0);
    for (int a = 0; a < 16; a++) mdl[a] = RST_VAL;
    read_all();

    p0 = n_wr; e0 = n_err;
    send_frame(32'h0015BEEF, 32, 12);
    mdl[5] = 16'hBEEF;
    chk("after_rst_wr_pulse_cycles", n_wr - p0, 1);
    chk("after_rst_frame_err_cycles", n_err - e0, 0);
    chk("after_rst_wr_addr", {28'h0, wr_addr}, 32'h5);
    chk("after_rst_wr_data", {16'h0, wr_data}, 32'hBEEF);
    read_check(4'h5);

    chk("pulse_and_err_overlap", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
